// File: rtl/tv_b_gone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tv_b_gone_pkg
// Description : Shared types, default widths and the carrier-threshold helper
//               for the TV-B-Gone IR output stage.
//               Build macro CARRIER_DUTY25_EN selects a 25 % carrier duty
//               (threshold div>>2, constant-on below div 4) instead of the
//               default 50 % duty (threshold div>>1, constant-on below div 2).
// Revision    : 1.0 - initial release
// ============================================================================
package tv_b_gone_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MARK  = 2'd1,
      S_SPACE = 2'd2
   } state_t;

   localparam int c_TIME_W_DEFAULT = 16;
   localparam int c_DIV_W_DEFAULT  = 10;

`ifdef CARRIER_DUTY25_EN
   localparam int unsigned c_CARRIER_SHIFT = 2;
`else
   localparam int unsigned c_CARRIER_SHIFT = 1;
`endif

   // Below this divider the "low" part of the carrier would be empty or the
   // whole period, so the LED is simply held on for the mark.
   localparam logic [31:0] c_CARRIER_MIN_DIV = 32'd1 << c_CARRIER_SHIFT;

   // Number of leading counter values per period that drive the LED high.
   function automatic logic [31:0] carrier_threshold(input logic [31:0] div);
      return div >> c_CARRIER_SHIFT;
   endfunction

   function automatic logic carrier_level(input logic [31:0] cc,
                                          input logic [31:0] div);
      if (div < c_CARRIER_MIN_DIV)
         return 1'b1;
      return (cc < carrier_threshold(div));
   endfunction

endpackage
`default_nettype wire

// File: rtl/ir_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module      : ir_carrier_gen
// Description : Carrier period counter plus duty comparator. The counter runs
//               0..div-1 and wraps. o_carrier is the carrier level for the
//               count the counter will hold in the NEXT cycle, so the parent
//               can register it and still get a high LED on the first mark
//               cycle. Duty selection follows CARRIER_DUTY25_EN (see pkg).
// Ports       : clk, rst_n   - clock, async active-low reset
//               i_clear      - force next count to 0 (has priority)
//               i_enable     - advance the count
//               i_div        - carrier period in clocks
//               o_carrier    - carrier level for the next count value
// Revision    : 1.0 - initial release
// ============================================================================
module ir_carrier_gen
   import tv_b_gone_pkg::*;
#(
   parameter int DIV_W = c_DIV_W_DEFAULT
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_carrier
);

   logic [DIV_W-1:0] r_cc;
   logic [DIV_W-1:0] w_cc_next;
   logic [DIV_W:0]   w_cc_inc;

   // One extra bit so the wrap test is safe for div = 0 and div = max.
   always_comb begin
      w_cc_inc  = {1'b0, r_cc} + {{DIV_W{1'b0}}, 1'b1};
      w_cc_next = r_cc;
      if (i_clear)
         w_cc_next = '0;
      else if (i_enable)
         w_cc_next = (w_cc_inc >= {1'b0, i_div}) ? '0 : w_cc_inc[DIV_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cc <= '0;
      else
         r_cc <= w_cc_next;
   end

   assign o_carrier = carrier_level(32'(w_cc_next), 32'(i_div));

endmodule
`default_nettype wire

// File: rtl/ir_pulse_modulator.sv
`default_nettype none
// ============================================================================
// Module      : ir_pulse_modulator
// Description : IR output stage. Accepts (mark, space) timing pairs over a
//               valid/ready handshake, drives a carrier-modulated IR LED for
//               the mark, holds it off for the space, and pulses code_done
//               when the last pair of a code completes. Build macro
//               CARRIER_DUTY25_EN selects 25 % carrier duty (default 50 %).
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_ena             - enable; low aborts to IDLE
//               i_carrier_div     - carrier period in clocks (latched on accept)
//               i_pulse_valid     - pair valid
//               o_pulse_ready     - IDLE and enabled
//               i_pulse_on/off    - mark/space length in time units
//               i_pulse_last      - final pair of a code
//               o_ir_out          - registered LED drive
//               o_busy            - in MARK or SPACE
//               o_code_done       - one-cycle pulse at end of code
// Revision    : 1.0 - initial release
// ============================================================================
module ir_pulse_modulator
   import tv_b_gone_pkg::*;
#(
   parameter int TIME_W   = c_TIME_W_DEFAULT,
   parameter int DIV_W    = c_DIV_W_DEFAULT,
   parameter int TICK_DIV = 10
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ena,
   input  logic [DIV_W-1:0]  i_carrier_div,
   input  logic              i_pulse_valid,
   output logic              o_pulse_ready,
   input  logic [TIME_W-1:0] i_pulse_on,
   input  logic [TIME_W-1:0] i_pulse_off,
   input  logic              i_pulse_last,
   output logic              o_ir_out,
   output logic              o_busy,
   output logic              o_code_done
);

   localparam int              c_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [c_PRE_W-1:0]  r_pre;
   logic [TIME_W-1:0]   r_units;      // remaining units of the current phase
   logic [TIME_W-1:0]   r_off;
   logic                r_last;
   logic [DIV_W-1:0]    r_div;
   logic                r_ir_out;
   logic                r_code_done;

   logic                w_accept;
   logic                w_unit_wrap;
   logic                w_last_unit;
   logic [DIV_W-1:0]    w_div_eff;
   logic                w_carrier;

   assign o_pulse_ready = (r_state == S_IDLE) && i_ena;
   assign o_busy        = (r_state != S_IDLE);
   assign o_ir_out      = r_ir_out;
   assign o_code_done   = r_code_done;
   assign w_accept      = i_pulse_valid && o_pulse_ready;

   // Prescaler wrap marks the end of one time unit; the phase ends when the
   // unit that wraps is the last remaining one.
   assign w_unit_wrap = (r_pre == c_PRE_LAST);
   assign w_last_unit = w_unit_wrap && (r_units == TIME_W'(1));

   // The divider is only latched at the accept edge, but the first mark
   // cycle's carrier level is computed at that same edge.
   assign w_div_eff = w_accept ? i_carrier_div : r_div;

   ir_carrier_gen #(
      .DIV_W (DIV_W)
   ) u_carrier (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   ((r_state != S_MARK) || !i_ena),
      .i_enable  (r_state == S_MARK),
      .i_div     (w_div_eff),
      .o_carrier (w_carrier)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (i_pulse_on != '0)
                  w_state_next = S_MARK;
               else if (i_pulse_off != '0)
                  w_state_next = S_SPACE;
            end
         end
         S_MARK: begin
            if (w_last_unit)
               w_state_next = (r_off != '0) ? S_SPACE : S_IDLE;
         end
         S_SPACE: begin
            if (w_last_unit)
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      if (!i_ena)
         w_state_next = S_IDLE;
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre       <= '0;
         r_units     <= '0;
         r_off       <= '0;
         r_last      <= 1'b0;
         r_div       <= '0;
         r_ir_out    <= 1'b0;
         r_code_done <= 1'b0;
      end else if (!i_ena) begin
         r_pre       <= '0;
         r_units     <= '0;
         r_ir_out    <= 1'b0;
         r_code_done <= 1'b0;
      end else begin
         r_ir_out    <= (w_state_next == S_MARK) && w_carrier;
         r_code_done <= 1'b0;
         if (w_accept) begin
            r_off   <= i_pulse_off;
            r_last  <= i_pulse_last;
            r_div   <= i_carrier_div;
            r_pre   <= '0;
            r_units <= (i_pulse_on != '0) ? i_pulse_on : i_pulse_off;
            if ((i_pulse_on == '0) && (i_pulse_off == '0))
               r_code_done <= i_pulse_last;
         end else if (r_state != S_IDLE) begin
            if (w_unit_wrap) begin
               r_pre <= '0;
               if (w_last_unit) begin
                  if ((r_state == S_MARK) && (r_off != '0)) begin
                     r_units <= r_off;
                  end else begin
                     r_units     <= '0;
                     r_code_done <= r_last;
                  end
               end else begin
                  r_units <= r_units - TIME_W'(1);
               end
            end else begin
               r_pre <= r_pre + c_PRE_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire
